// File: rtl/mem_scan_seq_if.sv
// Request and output-stream bundle for mem_scan_seq.
// The slave modport is the sequencer side; master is the requester/consumer side.
interface mem_scan_seq_if #(
    parameter int DW = 16,
    parameter int AW = 12
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          done;
    logic          out_of_bound;

    modport master (
        output req_valid, req_addr, out_ready,
        input  req_ready, out_valid, out_data, out_addr, done, out_of_bound
    );

    modport slave (
        input  req_valid, req_addr, out_ready,
        output req_ready, out_valid, out_data, out_addr, done, out_of_bound
    );
endinterface

// File: rtl/mem_scan_seq.sv
// Address-scan sequencer: walks an in-window start address down to LO, emitting one
// memory word per beat, or emits a single out_of_bound beat for out-of-window requests.
module mem_scan_seq #(
    parameter int DW    = 16,
    parameter int AW    = 12,
    parameter int DEPTH = 512,
    parameter int LO    = 128,
    parameter int HI    = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DW-1:0]            wr_data,
    mem_scan_seq_if.slave            bus,
    output logic                     busy
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [AW-1:0] LO_A   = AW'(LO);
    localparam logic [AW-1:0] HI_A   = AW'(HI);
    localparam logic [IW-1:0] LO_IDX = IW'(LO);

    typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] cur;
    logic          oob;
    logic [DW-1:0] data_q;
    logic [AW-1:0] addr_q;
    logic          done_q;
    logic          oob_q;
    logic          accept;
    logic          beat_hs;
    logic          last_beat;
    logic [IW-1:0] rd_idx;

    assign accept    = (state == IDLE) && bus.req_valid;
    assign beat_hs   = (state == EMIT) && bus.out_ready;
    assign last_beat = oob || (cur == LO_A);
    // Error beats still carry the word at LO so the consumer sees a defined value.
    assign rd_idx    = oob ? LO_IDX : cur[IW-1:0];

    // Memory array: no reset, contents survive rst_n; read in the datapath block sees old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid) state_nxt = READ;
            READ: state_nxt = EMIT;
            EMIT: if (bus.out_ready) state_nxt = last_beat ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Scan pointer and registered beat fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur    <= '0;
            oob    <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            done_q <= 1'b0;
            oob_q  <= 1'b0;
        end else begin
            if (accept) begin
                cur <= bus.req_addr;
                oob <= (bus.req_addr < LO_A) || (bus.req_addr > HI_A);
            end else if (beat_hs && !last_beat) begin
                cur <= cur - AW'(1);
            end
            if (state == READ) begin
                data_q <= mem[rd_idx];
                addr_q <= cur;
                done_q <= !oob && (cur == LO_A);
                oob_q  <= oob;
            end else if (beat_hs) begin
                done_q <= 1'b0;
                oob_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.req_ready    = (state == IDLE);
        bus.out_valid    = (state == EMIT);
        bus.out_data     = data_q;
        bus.out_addr     = addr_q;
        bus.done         = done_q;
        bus.out_of_bound = oob_q;
        busy             = (state != IDLE);
    end
endmodule
